dpwm_contador_param: RTL and testbench
======================================

Name: dpwm_contador_param

Overview:
Parametrised carrier-counter generation for the DPWM. It generates a programmable sawtooth or triangle carrier with runtime period and step, and double-buffered configuration. It also provides CHANNELS duty comparators that produce registered PWM outputs aligned to the carrier. It runs from the user-selected PWM clock, and its `cuenta` output feeds display/debug logic.

Parameters:
WIDTH, 10, carrier/period/step/duty width in bits
CHANNELS, 2, number of independent duty comparators/PWM outputs
PERIODO_RST, 1000, active period after reset
PASO_RST, 10, active step after reset

Ports:
CLK  input  1  counting clock (user-selected frequency)
RST  input  1  reset; asynchronous, active-high
EN  input  1  count enable; low = freeze carrier
MODO  input  1  0 = sawtooth, 1 = triangle (up/down)
PERIODO  input  WIDTH  requested carrier peak value
PASO  input  WIDTH  requested increment per enabled cycle
DUTY  input  CHANNELS*WIDTH  packed compare thresholds; channel i = DUTY[i*WIDTH +: WIDTH]
cuenta  output  WIDTH  carrier value
pwm_out  output  CHANNELS  PWM outputs
fin_periodo  output  1  one-cycle pulse at carrier period end
direccion  output  1  0 = counting up, 1 = counting down (always 0 in sawtooth)

Behaviour:
- Reset state (async, immediate):
  - cuenta=0, direccion=0, fin_periodo=0, pwm_out=0.
  - Active registers: periodo_a=PERIODO_RST, paso_a=PASO_RST, duty_a[i]=0, modo_a=0.
- Shadow/active configuration:
  - Active registers reload from PERIODO/PASO/DUTY/MODO on any cycle where EN=0.
  - They also reload on the edge where fin_periodo is being set to 1.
  - Input changes while EN=1 never affect the current period.
- All arithmetic uses WIDTH+1 bits, so cuenta+paso_a never overflows.
- Sawtooth (modo_a=0), on an enabled edge:
  - suma = cuenta + paso_a.
  - If suma > periodo_a: cuenta<=0 and fin_periodo<=1.
  - Otherwise: cuenta<=suma and fin_periodo<=0.
  - Defaults give 0,10,…,1000,0: 101 cycles per period.
- Triangle (modo_a=1), on an enabled edge:
  - Up (direccion=0): if suma >= periodo_a, cuenta<=periodo_a and direccion<=1; else cuenta<=suma.
  - Down: if cuenta <= paso_a, cuenta<=0, direccion<=0, fin_periodo<=1; else cuenta<=cuenta-paso_a.
  - Defaults give 0..1000..0: 200 cycles per period; the peak and zero each appear once.
- paso_a=0: cuenta holds, fin_periodo stays 0, direccion holds.
- periodo_a=0 with paso_a>0:
  - Sawtooth: cuenta stays 0 and fin_periodo=1 every enabled cycle.
  - Triangle: alternates direction; fin_periodo pulses every 2nd cycle.
- Active period lowered below cuenta (load while EN=0):
  - Sawtooth wraps to 0 on the next enabled edge, with fin_periodo.
  - Triangle-up clamps to periodo_a and turns down.
- Mode switch to sawtooth forces direccion<=0 on the load edge.
- EN=0: cuenta, direccion and pwm_out hold; fin_periodo<=0.
- pwm_out[i] is registered from the next carrier value: pwm_out[i] = (cuenta_next < duty_a_next[i]).
  - It is therefore valid in the same cycle as the matching cuenta, with zero latency relative to cuenta.
  - duty=0 gives always 0; duty > periodo gives always 1.
- fin_periodo is high in the cycle where cuenta==0 has just been entered by wrap or descent, never at reset release.
- Reset mid-period: all outputs return to reset values immediately, with no partial pulse.

Decomposition:
- Package dpwm_pkg: MODO_SIERRA=1'b0, MODO_TRIANGULO=1'b1, DIR_SUBE/DIR_BAJA, default period/step constants.
- Sub-module dpwm_comparador (WIDTH): registered compare of next carrier vs next duty; instantiated CHANNELS times via generate.
- The carrier FSM (direction + wrap) and the shadow registers live in the top module.

Test Plan:
- Defaults, EN=1 for 250 cycles → cuenta sequence 0,10,…,1000,0; fin_periodo high at cycles 101 and 202 only.
- MODO=1, PERIODO=100, PASO=25 → cuenta 0,25,50,75,100,75,50,25,0; direccion=1 during 75..25 descent; fin_periodo on the return to 0.
- Mid-period, change PERIODO 1000→500 with EN=1 → current period still peaks at 1000; next period wraps after 500; load lands on the fin_periodo edge.
- DUTY ch0=0, ch1=1001, period 1000 → pwm_out[0] never 1, pwm_out[1] always 1; ch0=300 → high for cuenta 0..290 (30 of 101 cycles).
- EN low for 20 cycles at cuenta=470, then PASO=0 → cuenta frozen at 470, no fin_periodo; PASO=7 restored → resumes 477.
- Assert RST at cuenta=640 mid-triangle-down → same cycle cuenta=0, direccion=0, pwm_out=0; after release, period and step revert to 1000/10.

Source files
------------

// File: rtl/dpwm_pkg.sv
// -----------------------------------------------------------------------------
// dpwm_pkg
// Shared constants and types for the parametrised DPWM carrier counter.
//
// Contents:
//   MODO_SIERRA / MODO_TRIANGULO : carrier shape selector values
//   dir_t (DIR_SUBE / DIR_BAJA)  : carrier direction state
//   WIDTH_DEF, CHANNELS_DEF      : default datapath width and channel count
//   PERIODO_DEF, PASO_DEF        : active period and step loaded at reset
// -----------------------------------------------------------------------------
package dpwm_pkg;

  // Carrier shape selector
  localparam logic MODO_SIERRA    = 1'b0;
  localparam logic MODO_TRIANGULO = 1'b1;

  // Carrier direction; sawtooth always stays in DIR_SUBE
  typedef enum logic {
    DIR_SUBE = 1'b0,
    DIR_BAJA = 1'b1
  } dir_t;

  // Default geometry
  localparam int WIDTH_DEF    = 10;
  localparam int CHANNELS_DEF = 2;

  // Active configuration after reset: 0..1000 in steps of 10
  localparam int PERIODO_DEF = 1000;
  localparam int PASO_DEF    = 10;

endpackage : dpwm_pkg

// File: rtl/dpwm_comparador.sv
// -----------------------------------------------------------------------------
// dpwm_comparador
// One PWM duty comparator. The output register is loaded from the carrier
// value and duty threshold that will be in effect after the same clock edge,
// so the PWM bit is aligned with the carrier it was compared against (no
// extra cycle of latency relative to the carrier register).
//
// Ports:
//   i_clk          : counting clock
//   i_rst          : asynchronous active-high reset (output forced low)
//   i_en           : count enable; low holds the PWM output
//   i_cuenta_next  : carrier value being registered on this edge
//   i_duty_next    : duty threshold being registered on this edge
//   o_pwm          : registered PWM output (carrier < duty)
// -----------------------------------------------------------------------------
module dpwm_comparador #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_cuenta_next,
  input  logic [WIDTH-1:0] i_duty_next,
  output logic             o_pwm
);

  logic r_pwm;
  logic w_pwm_next;

  // duty = 0 can never be exceeded -> always low;
  // duty above the carrier peak is always exceeded -> always high.
  assign w_pwm_next = (i_cuenta_next < i_duty_next);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm <= 1'b0;
    end else if (i_en) begin
      r_pwm <= w_pwm_next;
    end
  end

  assign o_pwm = r_pwm;

endmodule : dpwm_comparador

// File: rtl/dpwm_contador_param.sv
// -----------------------------------------------------------------------------
// dpwm_contador_param
// Parametrised DPWM carrier generator. Produces a sawtooth or triangle carrier
// with runtime period and step, double-buffered configuration, and CHANNELS
// registered PWM outputs aligned to the carrier.
//
// Ports:
//   CLK         : counting clock (user-selected PWM clock)
//   RST         : asynchronous active-high reset
//   EN          : count enable; low freezes the carrier and reloads config
//   MODO        : requested shape, 0 = sawtooth, 1 = triangle
//   PERIODO     : requested carrier peak value
//   PASO        : requested increment per enabled cycle
//   DUTY        : packed compare thresholds, channel i = DUTY[i*WIDTH +: WIDTH]
//   cuenta      : carrier value
//   pwm_out     : PWM outputs, bit i from channel i
//   fin_periodo : one-cycle pulse in the cycle the carrier returns to 0
//   direccion   : 0 = counting up, 1 = counting down (always 0 in sawtooth)
//
// Configuration is double-buffered: the inputs act as shadow registers and are
// copied to the active set while EN is low, or on the edge that ends a period.
// A change while counting therefore never disturbs the period in progress.
// -----------------------------------------------------------------------------
module dpwm_contador_param
  import dpwm_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int CHANNELS    = CHANNELS_DEF,
  parameter int PERIODO_RST = PERIODO_DEF,
  parameter int PASO_RST    = PASO_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      MODO,
  input  logic [WIDTH-1:0]          PERIODO,
  input  logic [WIDTH-1:0]          PASO,
  input  logic [CHANNELS*WIDTH-1:0] DUTY,
  output logic [WIDTH-1:0]          cuenta,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      fin_periodo,
  output logic                      direccion
);

  localparam logic [WIDTH-1:0] L_PERIODO_RST = WIDTH'(PERIODO_RST);
  localparam logic [WIDTH-1:0] L_PASO_RST    = WIDTH'(PASO_RST);

  // ---------------------------------------------------------------------------
  // State and active configuration
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]                r_cuenta;
  dir_t                            r_dir;
  logic                            r_fin;

  logic [WIDTH-1:0]                r_periodo_a;
  logic [WIDTH-1:0]                r_paso_a;
  logic                            r_modo_a;
  logic [CHANNELS-1:0][WIDTH-1:0]  r_duty_a;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]                w_cuenta_next;
  dir_t                            w_dir_next;
  logic                            w_fin_next;
  logic                            w_carga;
  logic [WIDTH:0]                  w_suma;
  logic [CHANNELS-1:0][WIDTH-1:0]  w_duty_next;

  // One extra bit so the sum can be compared against the period without wrap.
  assign w_suma = {1'b0, r_cuenta} + {1'b0, r_paso_a};

  // ---------------------------------------------------------------------------
  // Carrier next-state logic (direction FSM + wrap)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cuenta_next = r_cuenta;
    w_dir_next    = r_dir;
    w_fin_next    = 1'b0;
    w_carga       = 1'b0;

    // A zero step freezes the carrier exactly like EN=0, except that the
    // configuration is not reloaded (no period end ever occurs).
    if (EN && (r_paso_a != '0)) begin
      if (r_modo_a == MODO_TRIANGULO) begin
        if (r_dir == DIR_SUBE) begin
          // Clamp on the peak; also catches a period lowered below the
          // current carrier, which turns the carrier around immediately.
          if (w_suma >= {1'b0, r_periodo_a}) begin
            w_cuenta_next = r_periodo_a;
            w_dir_next    = DIR_BAJA;
          end else begin
            w_cuenta_next = w_suma[WIDTH-1:0];
          end
        end else begin
          // Landing on or below zero ends the period.
          if (r_cuenta <= r_paso_a) begin
            w_cuenta_next = '0;
            w_dir_next    = DIR_SUBE;
            w_fin_next    = 1'b1;
          end else begin
            w_cuenta_next = r_cuenta - r_paso_a;
          end
        end
      end else begin
        // Sawtooth: the peak value itself is still emitted, only a step that
        // would pass it wraps to zero.
        if (w_suma > {1'b0, r_periodo_a}) begin
          w_cuenta_next = '0;
          w_fin_next    = 1'b1;
        end else begin
          w_cuenta_next = w_suma[WIDTH-1:0];
        end
      end
    end

    // Active registers follow the inputs while idle, and pick them up on
    // the period-end edge so the next period starts with the new values.
    w_carga = !EN || w_fin_next;

    // Entering sawtooth must leave the direction flag clean.
    if (w_carga && (MODO == MODO_SIERRA)) begin
      w_dir_next = DIR_SUBE;
    end
  end

  // The comparators need the duty that will be active after this edge.
  assign w_duty_next = w_carga ? DUTY : r_duty_a;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cuenta <= '0;
      r_dir    <= DIR_SUBE;
      r_fin    <= 1'b0;
    end else begin
      r_cuenta <= w_cuenta_next;
      r_dir    <= w_dir_next;
      r_fin    <= w_fin_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Active (double-buffered) configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_periodo_a <= L_PERIODO_RST;
      r_paso_a    <= L_PASO_RST;
      r_modo_a    <= MODO_SIERRA;
      r_duty_a    <= '0;
    end else if (w_carga) begin
      r_periodo_a <= PERIODO;
      r_paso_a    <= PASO;
      r_modo_a    <= MODO;
      r_duty_a    <= w_duty_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty comparators, one per channel
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
      dpwm_comparador #(
        .WIDTH (WIDTH)
      ) u_cmp (
        .i_clk         (CLK),
        .i_rst         (RST),
        .i_en          (EN),
        .i_cuenta_next (w_cuenta_next),
        .i_duty_next   (w_duty_next[gi]),
        .o_pwm         (pwm_out[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cuenta      = r_cuenta;
  assign fin_periodo = r_fin;
  assign direccion   = r_dir;

endmodule : dpwm_contador_param

// File: tb/tb_dpwm_contador_param.sv
// -----------------------------------------------------------------------------
// tb_dpwm_contador_param
// Scoreboard bench: the stimulus process pushes the expected outputs for each
// clock edge into a queue; a monitor pops and compares after every edge.
// -----------------------------------------------------------------------------
module tb_dpwm_contador_param;

  localparam int W  = 10;
  localparam int CH = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            EN = 1'b0;
  logic            MODO = 1'b0;
  logic [W-1:0]    PERIODO = 10'd1000;
  logic [W-1:0]    PASO = 10'd10;
  logic [CH*W-1:0] DUTY = '0;
  logic [W-1:0]    cuenta;
  logic [CH-1:0]   pwm_out;
  logic            fin_periodo;
  logic            direccion;

  dpwm_contador_param #(
    .WIDTH       (W),
    .CHANNELS    (CH),
    .PERIODO_RST (1000),
    .PASO_RST    (10)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .MODO        (MODO),
    .PERIODO     (PERIODO),
    .PASO        (PASO),
    .DUTY        (DUTY),
    .cuenta      (cuenta),
    .pwm_out     (pwm_out),
    .fin_periodo (fin_periodo),
    .direccion   (direccion)
  );

  always #5 CLK = ~CLK;

  // mask bits: [3] cuenta, [2] pwm_out, [1] fin_periodo, [0] direccion
  typedef struct packed {
    logic [W-1:0]  c;
    logic [CH-1:0] p;
    logic          f;
    logic          d;
    logic [3:0]    m;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Triangle 0..100 step 25, expected after each enabled edge
  int tri_c [10] = '{25, 50, 75, 100, 75, 50, 25, 0, 25, 50};
  int tri_d [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  int tri_f [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  function automatic void chk(input string nm, input string campo,
                              input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, campo, act, req, $time);
    end
  endfunction

  // Monitor: one line per transaction, compare after every active edge
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        $display("[%0t] %s cuenta=%0d pwm=%b fin=%b dir=%b", $time, nm, cuenta, pwm_out,
                 fin_periodo, direccion);
        if (e.m[3]) chk(nm, "cuenta", 32'(cuenta), 32'(e.c));
        if (e.m[2]) chk(nm, "pwm_out", 32'(pwm_out), 32'(e.p));
        if (e.m[1]) chk(nm, "fin_periodo", 32'(fin_periodo), 32'(e.f));
        if (e.m[0]) chk(nm, "direccion", 32'(direccion), 32'(e.d));
      end
    end
  end

  // Drive EN for the next edge and queue what that edge must produce.
  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input logic en, input int c, input logic [CH-1:0] p,
                      input logic f, input logic d, input string nm);
    exp_t e;
    EN  = en;
    e.c = W'(c);
    e.p = p;
    e.f = f;
    e.d = d;
    e.m = 4'hF;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge CLK);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string nm);
    RST = 1'b1;
    EN  = 1'b0;
    #1;
    $display("[%0t] %s cuenta=%0d pwm=%b fin=%b dir=%b", $time, nm, cuenta, pwm_out,
             fin_periodo, direccion);
    chk(nm, "cuenta", 32'(cuenta), 32'd0);
    chk(nm, "pwm_out", 32'(pwm_out), 32'd0);
    chk(nm, "fin_periodo", 32'(fin_periodo), 32'd0);
    chk(nm, "direccion", 32'(direccion), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int j;
    int cnt;
    logic f;

    @(negedge CLK);

    // ---- T1: defaults, sawtooth 0,10..1000,0 ----
    MODO = 1'b0; PERIODO = 10'd1000; PASO = 10'd10; DUTY = '0;
    do_reset("reset_inicial");
    for (int k = 1; k <= 250; k++) begin
      tick(1'b1, 10 * (k % 101), 2'b00, (k % 101) == 0, 1'b0, "sierra_def");
    end

    // ---- T2: duty limits, then duty=300 loaded at period end ----
    DUTY = {10'd1001, 10'd0};
    do_reset("reset_duty");
    tick(1'b0, 0, 2'b00, 1'b0, 1'b0, "duty_carga");
    for (int k = 1; k <= 101; k++) begin
      if (k == 51) DUTY = {10'd1001, 10'd300};   // must not affect this period
      tick(1'b1, 10 * (k % 101), (k == 101) ? 2'b11 : 2'b10, k == 101, 1'b0, "duty_lim");
    end
    cnt = int'(pwm_out[0]);
    for (int k = 102; k <= 200; k++) begin
      c = 10 * (k - 101);
      tick(1'b1, c, {1'b1, c < 300}, 1'b0, 1'b0, "duty_300");
      cnt += int'(pwm_out[0]);
    end
    chk("duty_300", "ciclos_altos", 32'(cnt), 32'd30);

    // ---- T3: triangle 0..100 step 25 ----
    MODO = 1'b1; PERIODO = 10'd100; PASO = 10'd25;
    do_reset("reset_tri");
    tick(1'b0, 0, 2'b00, 1'b0, 1'b0, "tri_carga");
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, tri_c[i], 2'b11, tri_f[i] != 0, tri_d[i] != 0, "triangulo");
    end

    // ---- T4: period lowered while counting, applied at next period ----
    MODO = 1'b0; PERIODO = 10'd1000; PASO = 10'd10; DUTY = '0;
    do_reset("reset_periodo");
    for (int k = 1; k <= 160; k++) begin
      if (k == 51) PERIODO = 10'd500;
      if (k <= 101) begin
        c = 10 * (k % 101);
        f = (k % 101) == 0;
      end else begin
        j = (k - 101) % 51;
        c = 10 * j;
        f = (j == 0);
      end
      tick(1'b1, c, 2'b00, f, 1'b0, "cambio_periodo");
    end

    // ---- T5: freeze at 470, zero step, then step 7 ----
    PERIODO = 10'd1000; PASO = 10'd10;
    do_reset("reset_freeze");
    for (int k = 1; k <= 47; k++) tick(1'b1, 10 * k, 2'b00, 1'b0, 1'b0, "hacia_470");
    PASO = 10'd0;
    for (int k = 0; k < 20; k++) tick(1'b0, 470, 2'b00, 1'b0, 1'b0, "en_bajo");
    for (int k = 0; k < 5; k++) tick(1'b1, 470, 2'b00, 1'b0, 1'b0, "paso_cero");
    PASO = 10'd7;
    tick(1'b0, 470, 2'b00, 1'b0, 1'b0, "paso7_carga");
    tick(1'b1, 477, 2'b00, 1'b0, 1'b0, "paso7");
    tick(1'b1, 484, 2'b00, 1'b0, 1'b0, "paso7");
    tick(1'b1, 491, 2'b00, 1'b0, 1'b0, "paso7");

    // ---- T6: reset at 640 during triangle descent ----
    MODO = 1'b1; PERIODO = 10'd1000; PASO = 10'd10; DUTY = {10'd1001, 10'd300};
    do_reset("reset_tri2");
    tick(1'b0, 0, 2'b00, 1'b0, 1'b0, "tri2_carga");
    for (int k = 1; k <= 136; k++) begin
      c = (k <= 100) ? 10 * k : 1000 - 10 * (k - 100);
      tick(1'b1, c, {1'b1, c < 300}, 1'b0, k >= 100, "tri2");
    end
    PERIODO = 10'd100; PASO = 10'd25;          // must be ignored after reset
    do_reset("reset_bajada");
    for (int k = 1; k <= 5; k++) tick(1'b1, 10 * k, 2'b00, 1'b0, 1'b0, "tras_reset");

    // ---- drain ----
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge CLK);
    chk("drenaje", "cola", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_dpwm_contador_param
